vec_uop_expander: RTL
=====================

# vec_uop_expander

Expands each vector instruction popped from the flushable instruction queue into one micro-op per architectural register of its register group (LMUL = 1/2/4/8), issuing them one per cycle to the vector execution pipe. Sits directly downstream of the instruction FIFO: it drives that FIFO's `pop` from its own acceptance logic and consumes `pop_data`/`valid`. It shares the pipeline `flush` with the FIFO, so a misprediction empties both in the same cycle.

## Interface
- `DW`, default 32, width of the opaque instruction payload carried through to every micro-op.
- `REGW`, default 5, architectural vector register index width (32 registers).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush, synchronous, highest priority.
- `in_instr` in DW: instruction payload from the FIFO's `pop_data`.
- `in_vd`, `in_vs1`, `in_vs2` in REGW each: base register indices.
- `in_lmul` in 2: group code, 0→1, 1→2, 2→4, 3→8 micro-ops.
- `in_valid` in 1: FIFO not empty.
- `in_pop` out 1: pops the FIFO this cycle.
- `uop_instr` out DW: payload copied unchanged.
- `uop_vd`, `uop_vs1`, `uop_vs2` out REGW each: base + index, modulo 2^REGW.
- `uop_idx` out 3: micro-op index within the group.
- `uop_last` out 1: final micro-op of the instruction.
- `uop_valid` out 1: micro-op presented.
- `uop_ready` in 1: execution pipe accepts.
- `busy` out 1: instruction in progress, equal to `uop_valid`.

## Operation
- FSM with two states. IDLE: no micro-op held. ISSUE: output register holds a valid micro-op.
- Load condition: `in_pop = in_valid & ~flush & (IDLE | (uop_ready & uop_last))`.
- On load, the output register captures the payload and bases, `uop_idx` = 0, `uop_last` = (group count == 1), and a remaining count = group count − 1. State goes to ISSUE.
- In ISSUE with `uop_ready` and not last: `uop_idx`++, and `uop_vd`, `uop_vs1`, `uop_vs2` each +1 with 5-bit wrap (31+1 = 0). `uop_last` is set when the new index equals group count − 1.
- In ISSUE with `uop_ready` and last:
  - If a load happens in the same cycle, back-to-back expansion starts and the state stays ISSUE.
  - Otherwise the state goes to IDLE.
- Outputs stay stable while `uop_valid & ~uop_ready`.
- Register-group alignment and legality are not checked here; decode guarantees them.
- Flush: next cycle the state is IDLE, `uop_valid` = 0, and the counters are cleared. `in_pop` is forced 0 during the flush cycle. A micro-op accepted in the flush cycle counts as delivered; downstream discards it.
- Reset values: `uop_valid`, `uop_last`, `busy`, `uop_idx`, `uop_vd`, `uop_vs1`, `uop_vs2` = 0. `uop_instr` is don't-care. State is IDLE.
- Reset asserted mid-expansion abandons the instruction immediately, asynchronously.

## Timing
- `in_pop` is combinational from `in_valid`, `flush`, `uop_ready` and state. There is no combinational path from `in_*` data to the outputs.
- Latency: an instruction popped in cycle t shows its first micro-op in cycle t+1.
- Throughput: 1 micro-op/cycle sustained, including across instruction boundaries (no bubble when `uop_ready` stays high).
- An instruction of LMUL n occupies exactly n accepted cycles.
- With the FIFO empty, `uop_valid` drops the cycle after the last micro-op is accepted.

## Structure
- Package `vec_uop_pkg`:
  - `lmul_e` enum (LMUL1, LMUL2, LMUL4, LMUL8).
  - `uop_t` packed struct (instr, vd, vs1, vs2, idx, last).
  - `NUM_VREGS` = 32.
  - Function `lmul_count(lmul_e)` returning 1..8.
- No sub-module. The FSM, index counter and three register adders live in one module. The FIFO is instantiated alongside by the parent.
- Assertions:
  - `in_pop |-> in_valid`.
  - Outputs stable under stall.
  - `uop_idx < lmul_count`.

## Test plan
- LMUL2, vd=4, vs1=8, vs2=12, `uop_ready`=1 → pop at t; t+1: (4,8,12, idx0, last0); t+2: (5,9,13, idx1, last1); t+3: `uop_valid`=0.
- Two LMUL1 instructions queued, ready=1 → second pop coincides with first acceptance; micro-ops on consecutive cycles, both `uop_last`=1, no bubble.
- LMUL8, vd=28, with ready low on idx 3 for 3 cycles → outputs frozen at vd=31 during the stall, then vd 0,1,2,3, each wrapping; 8 acceptances total.
- Flush at idx 2 of an LMUL4 instruction, FIFO non-empty → `in_pop`=0 that cycle; next cycle `uop_valid`=0 and IDLE; a new pop the cycle after.
- Reset low mid-expansion (LMUL4, idx 1) → `uop_valid`=0 immediately, all listed outputs 0. After release and `in_valid`=1, the first micro-op appears 1 cycle after the pop.

Source files
------------

// File: rtl/vec_uop_pkg.sv
// vec_uop_pkg: shared types and helpers for the vector micro-op expander.
//   lmul_e      - register-group code (1/2/4/8 registers per instruction)
//   state_e     - expander FSM states
//   uop_t       - one micro-op as seen by the execution pipe, at the default
//                 widths (32-bit payload, 5-bit register index)
//   NUM_VREGS   - number of architectural vector registers
//   lmul_count  - number of micro-ops an LMUL code expands into
package vec_uop_pkg;

  localparam int NUM_VREGS = 32;
  localparam int UOP_DW    = 32;
  localparam int UOP_REGW  = $clog2(NUM_VREGS);

  typedef enum logic [1:0] {
    LMUL1 = 2'd0,
    LMUL2 = 2'd1,
    LMUL4 = 2'd2,
    LMUL8 = 2'd3
  } lmul_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [UOP_DW-1:0]   instr;
    logic [UOP_REGW-1:0] vd;
    logic [UOP_REGW-1:0] vs1;
    logic [UOP_REGW-1:0] vs2;
    logic [2:0]          idx;
    logic                last;
  } uop_t;

  // 1, 2, 4 or 8 micro-ops per instruction.
  function automatic logic [3:0] lmul_count(input lmul_e lmul);
    return 4'd1 << lmul;
  endfunction

endpackage

// File: rtl/vec_uop_expander.sv
// vec_uop_expander: expands each vector instruction taken from the
// instruction FIFO into one micro-op per register of its group, one per cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous pipeline flush, highest priority
//   in_instr/in_vd/in_vs1/in_vs2/in_lmul/in_valid
//                       head of the instruction FIFO (pop_data / not empty)
//   in_pop              pops the FIFO this cycle
//   uop_instr/uop_vd/uop_vs1/uop_vs2/uop_idx/uop_last/uop_valid
//                       registered micro-op presented to the execution pipe
//   uop_ready           execution pipe accepts the presented micro-op
//   busy                instruction in progress; mirrors the FSM state
//                       (high exactly in S_ISSUE), so it doubles as the
//                       state observation point
//
// Handshake: a micro-op transfers on every rising edge where uop_valid and
// uop_ready are both high. While uop_valid is high and uop_ready low, every
// uop_* output holds its value (only flush or reset can withdraw it).
// On the input side, in_pop is the FIFO's pop strobe: it is only ever high
// together with in_valid, and the head entry is captured on that same edge.
module vec_uop_expander
  import vec_uop_pkg::*;
#(
  parameter int DW   = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [DW-1:0]   in_instr,
  input  logic [REGW-1:0] in_vd,
  input  logic [REGW-1:0] in_vs1,
  input  logic [REGW-1:0] in_vs2,
  input  logic [1:0]      in_lmul,
  input  logic            in_valid,
  output logic            in_pop,
  output logic [DW-1:0]   uop_instr,
  output logic [REGW-1:0] uop_vd,
  output logic [REGW-1:0] uop_vs1,
  output logic [REGW-1:0] uop_vs2,
  output logic [2:0]      uop_idx,
  output logic            uop_last,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic            busy
);

  state_e     state, state_n;
  logic       load;
  logic       advance;
  logic [3:0] grp_cnt;
  logic [2:0] last_idx;  // group count - 1 of the instruction in flight

  always_comb begin
    grp_cnt = lmul_count(lmul_e'(in_lmul));
    // Take a new instruction when nothing is held, or when the final
    // micro-op of the current one leaves this cycle (no bubble between
    // instructions).
    load    = in_valid & ~flush & ((state == S_IDLE) | (uop_ready & uop_last));
    advance = (state == S_ISSUE) & uop_ready & ~uop_last;

    state_n = state;
    if (flush) begin
      state_n = S_IDLE;
    end else if (load) begin
      state_n = S_ISSUE;
    end else if ((state == S_ISSUE) && uop_ready && uop_last) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      uop_instr <= '0;
      uop_vd    <= '0;
      uop_vs1   <= '0;
      uop_vs2   <= '0;
      uop_idx   <= '0;
      uop_last  <= 1'b0;
      last_idx  <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        uop_idx  <= '0;
        uop_last <= 1'b0;
        last_idx <= '0;
      end else if (load) begin
        uop_instr <= in_instr;
        uop_vd    <= in_vd;
        uop_vs1   <= in_vs1;
        uop_vs2   <= in_vs2;
        uop_idx   <= '0;
        uop_last  <= (grp_cnt == 4'd1);
        last_idx  <= 3'(grp_cnt - 4'd1);
      end else if (advance) begin
        // Register indices wrap modulo 2^REGW (31 + 1 = 0).
        uop_idx  <= uop_idx + 3'd1;
        uop_vd   <= uop_vd + REGW'(1);
        uop_vs1  <= uop_vs1 + REGW'(1);
        uop_vs2  <= uop_vs2 + REGW'(1);
        uop_last <= ((uop_idx + 3'd1) == last_idx);
      end
    end
  end

  assign in_pop    = load;
  assign uop_valid = (state == S_ISSUE);
  assign busy      = uop_valid;

  a_pop_needs_valid : assert property (
    @(posedge clk) disable iff (!rst) in_pop |-> in_valid);

  a_stable_under_stall : assert property (
    @(posedge clk) disable iff (!rst)
    (uop_valid & ~uop_ready & ~flush) |=>
      (uop_valid & $stable(uop_instr) & $stable(uop_vd) & $stable(uop_vs1) &
       $stable(uop_vs2) & $stable(uop_idx) & $stable(uop_last)));

  a_idx_in_group : assert property (
    @(posedge clk) disable iff (!rst) uop_valid |-> (uop_idx <= last_idx));

endmodule
